mult_pipe: RTL and testbench

Parametrised, pipelined SW x SW integer multiplier with valid/ready handshaking on both sides. It is the next generation of the single-register mantissa multiplier in the FPU datapath. It adds configurable latency, per-operation signed/unsigned mode and backpressure with bubble collapsing. It sits between operand alignment and normalisation/rounding in the KOA/FPU multiply path.

---
 rtl/mult_pipe.sv | 105 ++++++++++
 tb/tb_mult_pipe.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_pipe.sv
// Pipelined SW x SW multiplier (signed/unsigned per operation) with valid/ready on both sides.
// Optional MULT_STICKY_EN adds sticky_o = OR of product bits [SW-3:0], carried with each product.
module mult_pipe #(
  parameter int SW     = 24,
  parameter int STAGES = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic            signed_i,
  input  logic [SW-1:0]   Data_A_i,
  input  logic [SW-1:0]   Data_B_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [2*SW-1:0] Data_S_o,
`ifdef MULT_STICKY_EN
  output logic            sticky_o,
`endif
  output logic            busy_o
);

  logic              r_v    [1:STAGES];
  logic [2*SW-1:0]   r_data [1:STAGES];
  logic [STAGES:1]   w_adv;
  logic              w_accept;
  logic [2*SW-1:0]   w_a_ext;
  logic [2*SW-1:0]   w_b_ext;
  logic [2*SW-1:0]   w_prod;
  logic              w_busy;

  // Extending both operands to 2*SW bits makes the low 2*SW bits of the product exact in either mode.
  assign w_a_ext  = signed_i ? {{SW{Data_A_i[SW-1]}}, Data_A_i} : {{SW{1'b0}}, Data_A_i};
  assign w_b_ext  = signed_i ? {{SW{Data_B_i[SW-1]}}, Data_B_i} : {{SW{1'b0}}, Data_B_i};
  assign w_prod   = w_a_ext * w_b_ext;

  // Back-to-front advance chain: any empty stage lets everything upstream of it move.
  always_comb begin
    w_adv         = '0;
    w_adv[STAGES] = ~r_v[STAGES] | ready_i;
    for (int k = STAGES - 1; k >= 1; k--) begin
      w_adv[k] = ~r_v[k] | w_adv[k+1];
    end
  end

  always_comb begin
    w_busy = 1'b0;
    for (int k = 1; k <= STAGES; k++) begin
      w_busy = w_busy | r_v[k];
    end
  end

  assign ready_o  = w_adv[1];
  assign w_accept = valid_i & w_adv[1];
  assign valid_o  = r_v[STAGES];
  assign Data_S_o = r_data[STAGES];
  assign busy_o   = w_busy;

`ifdef MULT_STICKY_EN
  logic r_sticky [1:STAGES];
  assign sticky_o = r_sticky[STAGES];
`endif

  for (genvar k = 1; k <= STAGES; k++) begin : g_stage
    logic            w_vin;
    logic [2*SW-1:0] w_din;
`ifdef MULT_STICKY_EN
    logic            w_sin;
`endif

    if (k == 1) begin : g_first
      assign w_vin = w_accept;
      assign w_din = w_prod;
`ifdef MULT_STICKY_EN
      assign w_sin = |w_prod[SW-3:0];
`endif
    end else begin : g_rest
      assign w_vin = r_v[k-1];
      assign w_din = r_data[k-1];
`ifdef MULT_STICKY_EN
      assign w_sin = r_sticky[k-1];
`endif
    end

    // Data only loads with a valid incoming word so an idle output keeps the last product.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v[k]    <= 1'b0;
        r_data[k] <= '0;
`ifdef MULT_STICKY_EN
        r_sticky[k] <= 1'b0;
`endif
      end else if (w_adv[k]) begin
        r_v[k] <= w_vin;
        if (w_vin) begin
          r_data[k] <= w_din;
`ifdef MULT_STICKY_EN
          r_sticky[k] <= w_sin;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_pipe.sv
// Scoreboard bench for mult_pipe (SW=24, STAGES=3): directed vectors, queue of expected products.
module tb_mult_pipe;
  localparam int SW = 24;
  localparam int STAGES = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_i;
  logic            ready_o;
  logic            signed_i;
  logic [SW-1:0]   Data_A_i;
  logic [SW-1:0]   Data_B_i;
  logic            valid_o;
  logic            ready_i;
  logic [2*SW-1:0] Data_S_o;
  logic            busy_o;
`ifdef MULT_STICKY_EN
  logic            sticky_o;
`endif

  mult_pipe #(.SW(SW), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .signed_i(signed_i),
    .Data_A_i(Data_A_i), .Data_B_i(Data_B_i), .valid_o(valid_o), .ready_i(ready_i),
    .Data_S_o(Data_S_o),
`ifdef MULT_STICKY_EN
    .sticky_o(sticky_o),
`endif
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2*SW-1:0] d;
    logic            s;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Holds the operand until the DUT accepts it; leaves valid_i asserted for back-to-back use.
  task automatic send(input logic [SW-1:0] a, input logic [SW-1:0] b, input logic sgn,
                      input logic [2*SW-1:0] exp_d, input logic exp_s);
    logic got;
    int   n;
    valid_i  = 1'b1;
    Data_A_i = a;
    Data_B_i = b;
    signed_i = sgn;
    got = 1'b0;
    n   = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      got = ready_o;
      @(posedge clk);
      #1;
      n++;
    end
    if (got) q.push_back('{d: exp_d, s: exp_s});
    else chk("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q.size() != 0 || busy_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Monitor: pops on every handshake and checks that stalled outputs stay put.
  logic            prev_stall = 1'b0;
  logic [2*SW-1:0] prev_d;
`ifdef MULT_STICKY_EN
  logic            prev_s;
`endif
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 64'(valid_o), 64'd1);
        chk("hold_data", 64'(Data_S_o), 64'(prev_d));
`ifdef MULT_STICKY_EN
        chk("hold_sticky", 64'(sticky_o), 64'(prev_s));
`endif
      end
      if (valid_o && ready_i) begin
        if (q.size() == 0) begin
          chk("unexpected_output", 64'(Data_S_o), 64'd0);
          chk("unexpected_valid", 64'd1, 64'd0);
        end else begin
          e = q.pop_front();
          chk("product", 64'(Data_S_o), 64'(e.d));
`ifdef MULT_STICKY_EN
          chk("sticky", 64'(sticky_o), 64'(e.s));
`endif
        end
      end
      prev_stall = valid_o && !ready_i;
      prev_d     = Data_S_o;
`ifdef MULT_STICKY_EN
      prev_s     = sticky_o;
`endif
    end
  end

  initial begin
    logic saw_not_ready;
    int   n;
    rst = 1'b1; valid_i = 1'b0; signed_i = 1'b0;
    Data_A_i = '0; Data_B_i = '0; ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_valid_o", 64'(valid_o), 64'd0);
    chk("rst_busy_o", 64'(busy_o), 64'd0);
    chk("rst_data", 64'(Data_S_o), 64'd0);
    chk("rst_ready_o", 64'(ready_o), 64'd1);
    @(posedge clk); #1;

    // Latency of a single unsigned max x max
    send(24'hFFFFFF, 24'hFFFFFF, 1'b0, 48'hFFFFFE000001, 1'b1);
    valid_i = 1'b0;
    @(negedge clk); chk("lat_edge0", 64'(valid_o), 64'd0);
    @(negedge clk); chk("lat_edge1", 64'(valid_o), 64'd0);
    @(negedge clk); chk("lat_edge2", 64'(valid_o), 64'd1);
    @(negedge clk); chk("lat_after", 64'(valid_o), 64'd0);
    chk("retain_data", 64'(Data_S_o), 64'h0000FFFFFE000001);
    @(posedge clk); #1;

    // Same operands, signed then unsigned back-to-back, plus a few more modes
    send(24'hFFFFFF, 24'h000002, 1'b1, 48'hFFFFFFFFFFFE, 1'b1);
    send(24'hFFFFFF, 24'h000002, 1'b0, 48'h000001FFFFFE, 1'b1);
    send(24'h800000, 24'h800000, 1'b1, 48'h400000000000, 1'b0);
    send(24'hFFFFFD, 24'h000005, 1'b1, 48'hFFFFFFFFFFF1, 1'b1);
    send(24'h123456, 24'h000010, 1'b0, 48'h000001234560, 1'b1);
    valid_i = 1'b0;
    drain();
    @(posedge clk); #1;

    // Backpressure with a full pipe
    ready_i = 1'b0;
    saw_not_ready = 1'b0;
    fork
      begin
        for (int i = 1; i <= 5; i++)
          send(24'(i), 24'h000010, 1'b0, 48'(i * 16), 1'b1);
        valid_i = 1'b0;
      end
      begin
        n = 0;
        while (!valid_o && n < 20) begin @(negedge clk); n++; end
        chk("stall_first_valid", 64'(valid_o), 64'd1);
        repeat (4) begin
          @(negedge clk);
          chk("stall_data", 64'(Data_S_o), 64'h10);
          if (!ready_o) saw_not_ready = 1'b1;
        end
        chk("stall_ready_dropped", 64'(saw_not_ready), 64'd1);
        @(posedge clk); #1;
        ready_i = 1'b1;
      end
    join
    drain();
    @(posedge clk); #1;

    // Asynchronous reset with operations in flight
    send(24'h000007, 24'h000003, 1'b0, 48'h15, 1'b1);
    send(24'h000009, 24'h000003, 1'b0, 48'h1B, 1'b1);
    send(24'h00000B, 24'h000003, 1'b0, 48'h21, 1'b1);
    valid_i = 1'b0;
    #2 rst = 1'b1;
    q.delete();
    #1;
    chk("async_rst_valid", 64'(valid_o), 64'd0);
    chk("async_rst_busy", 64'(busy_o), 64'd0);
    chk("async_rst_data", 64'(Data_S_o), 64'd0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_no_output", 64'(valid_o), 64'd0);
    end
    @(posedge clk); #1;

`ifdef MULT_STICKY_EN
    send(24'h800000, 24'h000001, 1'b0, 48'h000000800000, 1'b0);
    send(24'h000003, 24'h000001, 1'b0, 48'h000000000003, 1'b1);
    valid_i = 1'b0;
    drain();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
